// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial frame transmitter, MSB first, with an appended parity bit.
// Ports: clk, reset (async, active-low), in_data/in_valid/in_ready (word handshake),
//   out/out_valid (registered serial line), busy (frame in progress),
//   sof (registered, high with the first data bit; present only when the
//   PARITY_TX_SOF_EN macro is defined).
module parity_frame_tx #(
  parameter int unsigned DATA_W   = 2,
  parameter bit          ODD      = 1'b1,
  parameter bit          IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy
`ifdef PARITY_TX_SOF_EN
  ,
  output logic              sof
`endif
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;
`ifdef PARITY_TX_SOF_EN
  logic              sof_q, sof_d;
`endif

  assign in_ready = (state_q != S_DATA);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef PARITY_TX_SOF_EN
    sof_d       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_PAR: begin
        if (accept) begin
          // MSB goes straight to the line; shift_q keeps the rest,
          // next bit always at the top.
          state_d     = S_DATA;
          cnt_d       = CW'(DATA_W - 1);
          out_d       = in_data[DATA_W-1];
          shift_d     = in_data << 1;
          par_d       = (^in_data) ^ ODD;
          out_valid_d = 1'b1;
`ifdef PARITY_TX_SOF_EN
          sof_d       = 1'b1;
`endif
        end else if (state_q == S_PAR) begin
          state_d     = S_IDLE;
          out_d       = IDLE_BIT;
          out_valid_d = 1'b0;
        end
      end
      S_DATA: begin
        out_valid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_PAR;
          out_d   = par_q;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          out_d   = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_d       = IDLE_BIT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef PARITY_TX_SOF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sof_q <= 1'b0;
    end else begin
      sof_q <= sof_d;
    end
  end

  assign sof = sof_q;
`endif

endmodule
